router_output_arbiter: RTL and testbench

ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

---
 rtl/router_output_arbiter_pkg.sv | 24 ++
 rtl/rr_priority_select.sv | 35 +++
 rtl/router_output_arbiter.sv | 108 ++++++++++
 tb/tb_router_output_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_output_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_output_arbiter_pkg
// Description : Shared types and defaults for the router output arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package router_output_arbiter_pkg;

  localparam int DEFAULT_NUM_PORTS     = 5;
  localparam int DEFAULT_LOG_NUM_PORTS = 3;
  localparam int DEFAULT_WORD_WIDTH    = 128;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // The tail flag always rides in the most significant bit of a flit.
  function automatic int tail_bit_pos(input int word_width);
    return word_width - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_select
// Description : Combinational round-robin picker: first set req bit at or
//               after rr_ptr, wrapping modulo NUM_PORTS.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select
  import router_output_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = DEFAULT_NUM_PORTS,
  parameter int LOG_NUM_PORTS = DEFAULT_LOG_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0]     req,
  input  logic [LOG_NUM_PORTS-1:0] rr_ptr,
  output logic [LOG_NUM_PORTS-1:0] index,
  output logic                     found
);

  always_comb begin
    int w_pos;
    w_pos = 0;
    index = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_pos = (int'(rr_ptr) + k) % NUM_PORTS;
      if (!found && req[w_pos]) begin
        found = 1'b1;
        index = w_pos[LOG_NUM_PORTS-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : router_output_arbiter
// Description : Round-robin output-port arbiter with registered flit output.
//               ROUTER_ARB_PACKET_LOCK_EN holds the grant until the tail flit;
//               otherwise arbitration rotates after every flit.
// Revision    : 1.0 - initial release
// ============================================================================
module router_output_arbiter
  import router_output_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = DEFAULT_NUM_PORTS,
  parameter int LOG_NUM_PORTS = DEFAULT_LOG_NUM_PORTS,
  parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] data_in,
  input  logic                            out_ready,
  output logic [NUM_PORTS-1:0]            pop,
  output logic [WORD_WIDTH-1:0]           data_out,
  output logic                            valid_out,
  output logic [LOG_NUM_PORTS-1:0]        grant_idx,
  output logic                            busy
);

  localparam logic [0:0] ST_IDLE   = ARB_IDLE;
  localparam logic [0:0] ST_LOCKED = ARB_LOCKED;
  localparam int         TAIL_POS  = tail_bit_pos(WORD_WIDTH);

  logic [0:0]               r_state;
  logic [LOG_NUM_PORTS-1:0] r_rr_ptr;
  logic [LOG_NUM_PORTS-1:0] r_grant_idx;
  logic [WORD_WIDTH-1:0]    r_data_out;
  logic                     r_valid_out;

  logic [LOG_NUM_PORTS-1:0] w_sel_idx;
  logic                     w_sel_found;
  logic                     w_locked;
  logic                     w_pop_fire;
  logic                     w_release;
  logic [WORD_WIDTH-1:0]    w_flit;
  logic [LOG_NUM_PORTS-1:0] w_next_ptr;

  rr_priority_select #(
    .NUM_PORTS     (NUM_PORTS),
    .LOG_NUM_PORTS (LOG_NUM_PORTS)
  ) u_select (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .index  (w_sel_idx),
    .found  (w_sel_found)
  );

  assign w_locked   = (r_state == ST_LOCKED);
  assign w_pop_fire = w_locked & req[r_grant_idx] & out_ready;
  assign w_flit     = data_in[r_grant_idx*WORD_WIDTH +: WORD_WIDTH];
  assign w_next_ptr = (r_grant_idx == LOG_NUM_PORTS'(NUM_PORTS - 1)) ?
                      '0 : r_grant_idx + 1'b1;

`ifdef ROUTER_ARB_PACKET_LOCK_EN
  assign w_release = w_pop_fire & w_flit[TAIL_POS];
`else
  assign w_release = w_pop_fire;
`endif

  always_comb begin
    pop = '0;
    if (w_pop_fire) pop[r_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_pop_fire;
      if (w_pop_fire) r_data_out <= w_flit;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_found) begin
            r_grant_idx <= w_sel_idx;
            r_state     <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Bubbles and stalls simply hold here; only a releasing pop rotates.
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign grant_idx = r_grant_idx;
  assign busy      = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_router_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_output_arbiter
// Description : Directed, table-driven bench for router_output_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_output_arbiter;

  localparam int NP = 5;
  localparam int LW = 3;
  localparam int WW = 16;
`ifdef ROUTER_ARB_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct {
    logic          rdy;
    logic [NP-1:0] hold;
    logic [NP-1:0] e_pop;
    logic          e_busy;
    logic [LW-1:0] e_grant;
    logic          e_valid;
    logic [WW-1:0] e_data;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req;
  logic [NP*WW-1:0] data_in;
  logic             out_ready;
  logic [NP-1:0]    pop;
  logic [WW-1:0]    data_out;
  logic             valid_out;
  logic [LW-1:0]    grant_idx;
  logic             busy;

  logic [WW-1:0] fifo [NP][8];
  int            rd [NP];
  int            wr [NP];
  logic [NP-1:0] hold_m;
  int            errors = 0;
  int            checks = 0;
  vec_t          rr_tab [13];

  router_output_arbiter #(
    .NUM_PORTS     (NP),
    .LOG_NUM_PORTS (LW),
    .WORD_WIDTH    (WW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .pop       (pop),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [WW-1:0] f);
    fifo[p][wr[p]] = f;
    wr[p]++;
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      logic ne;
      ne = (rd[p] != wr[p]);
      req[p] = ne && !hold_m[p];
      data_in[p*WW +: WW] = ne ? fifo[p][rd[p]] : '0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      rd[p] = 0;
      wr[p] = 0;
    end
    hold_m    = '0;
    out_ready = 1'b0;
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a falling edge: drive, check, clock once, retire popped flits.
  task automatic step(input logic rdy, input logic [NP-1:0] hold,
                      input logic [NP-1:0] e_pop, input logic e_busy,
                      input logic [LW-1:0] e_grant, input logic e_valid,
                      input logic [WW-1:0] e_data, input string tag);
    logic [NP-1:0] sp;
    out_ready = rdy;
    hold_m    = hold;
    drive_inputs();
    #1;
    chk({tag, ".pop"},   32'(pop),       32'(e_pop));
    chk({tag, ".busy"},  32'(busy),      32'(e_busy));
    chk({tag, ".grant"}, 32'(grant_idx), 32'(e_grant));
    chk({tag, ".valid"}, 32'(valid_out), 32'(e_valid));
    chk({tag, ".data"},  32'(data_out),  32'(e_data));
    sp = pop;
    @(posedge clk);
    for (int p = 0; p < NP; p++)
      if (sp[p] && rd[p] != wr[p]) rd[p]++;
    @(negedge clk);
  endtask

  initial begin
    rr_tab[0]  = '{1'b1, 5'h00, 5'b00000, 1'b0, 3'd0, 1'b0, 16'h0000};
    rr_tab[1]  = '{1'b1, 5'h00, 5'b00001, 1'b1, 3'd0, 1'b0, 16'h0000};
    rr_tab[2]  = '{1'b1, 5'h00, 5'b00000, 1'b0, 3'd0, 1'b1, 16'h8000};
    rr_tab[3]  = '{1'b1, 5'h00, 5'b00010, 1'b1, 3'd1, 1'b0, 16'h8000};
    rr_tab[4]  = '{1'b1, 5'h00, 5'b00000, 1'b0, 3'd1, 1'b1, 16'h8001};
    rr_tab[5]  = '{1'b1, 5'h00, 5'b00100, 1'b1, 3'd2, 1'b0, 16'h8001};
    rr_tab[6]  = '{1'b1, 5'h00, 5'b00000, 1'b0, 3'd2, 1'b1, 16'h8002};
    rr_tab[7]  = '{1'b1, 5'h00, 5'b01000, 1'b1, 3'd3, 1'b0, 16'h8002};
    rr_tab[8]  = '{1'b1, 5'h00, 5'b00000, 1'b0, 3'd3, 1'b1, 16'h8003};
    rr_tab[9]  = '{1'b1, 5'h00, 5'b10000, 1'b1, 3'd4, 1'b0, 16'h8003};
    rr_tab[10] = '{1'b1, 5'h00, 5'b00000, 1'b0, 3'd4, 1'b1, 16'h8004};
    rr_tab[11] = '{1'b1, 5'h00, 5'b00001, 1'b1, 3'd0, 1'b0, 16'h8004};
    rr_tab[12] = '{1'b1, 5'h00, 5'b00000, 1'b0, 3'd0, 1'b1, 16'h8010};

    // Reset state with requests already pending.
    rst_n     = 1'b0;
    out_ready = 1'b1;
    hold_m    = '0;
    for (int p = 0; p < NP; p++) begin
      rd[p] = 0;
      wr[p] = 0;
    end
    push(2, 16'h8021);
    push(4, 16'h8041);
    drive_inputs();
    #1;
    chk("rst.pop",   32'(pop),       32'h0);
    chk("rst.busy",  32'(busy),      32'h0);
    chk("rst.grant", 32'(grant_idx), 32'h0);
    chk("rst.valid", 32'(valid_out), 32'h0);
    chk("rst.data",  32'(data_out),  32'h0);

    // Round robin over five single-flit requesters.
    apply_reset();
    push(0, 16'h8000);
    push(0, 16'h8010);
    for (int p = 1; p < NP; p++) push(p, 16'h8000 | 16'(p));
    for (int i = 0; i < 13; i++)
      step(rr_tab[i].rdy, rr_tab[i].hold, rr_tab[i].e_pop, rr_tab[i].e_busy,
           rr_tab[i].e_grant, rr_tab[i].e_valid, rr_tab[i].e_data,
           $sformatf("rr[%0d]", i));

    // Two-cycle downstream stall on each flit of a packet.
    apply_reset();
    push(0, 16'h0011);
    push(0, 16'h8012);
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd0, 1'b0, 16'h0000, "st0");
    step(1'b0, 5'h0, 5'b00000, 1'b1, 3'd0, 1'b0, 16'h0000, "st1");
    step(1'b0, 5'h0, 5'b00000, 1'b1, 3'd0, 1'b0, 16'h0000, "st2");
    step(1'b1, 5'h0, 5'b00001, 1'b1, 3'd0, 1'b0, 16'h0000, "st3");
    step(1'b0, 5'h0, 5'b00000, LOCK, 3'd0, 1'b1, 16'h0011, "st4");
    step(1'b0, 5'h0, 5'b00000, 1'b1, 3'd0, 1'b0, 16'h0011, "st5");
    step(1'b1, 5'h0, 5'b00001, 1'b1, 3'd0, 1'b0, 16'h0011, "st6");
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd0, 1'b1, 16'h8012, "st7");

    // Asynchronous reset while port 2 holds the output.
    apply_reset();
    push(2, 16'h0021);
    push(2, 16'h8022);
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd0, 1'b0, 16'h0000, "mr0");
    step(1'b1, 5'h0, 5'b00100, 1'b1, 3'd2, 1'b0, 16'h0000, "mr1");
    drive_inputs();
    #1;
    chk("mr.pre.busy",  32'(busy),      32'(LOCK));
    chk("mr.pre.pop",   32'(pop),       LOCK ? 32'h4 : 32'h0);
    chk("mr.pre.grant", 32'(grant_idx), 32'h2);
    chk("mr.pre.valid", 32'(valid_out), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr.busy",  32'(busy),      32'h0);
    chk("mr.pop",   32'(pop),       32'h0);
    chk("mr.grant", 32'(grant_idx), 32'h0);
    chk("mr.valid", 32'(valid_out), 32'h0);
    chk("mr.data",  32'(data_out),  32'h0);

`ifdef ROUTER_ARB_PACKET_LOCK_EN
    // Three-flit packet on port 1, then port 2 gets its turn.
    apply_reset();
    push(1, 16'h0011);
    push(1, 16'h0012);
    push(1, 16'h8013);
    push(2, 16'h8021);
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd0, 1'b0, 16'h0000, "pk0");
    step(1'b1, 5'h0, 5'b00010, 1'b1, 3'd1, 1'b0, 16'h0000, "pk1");
    step(1'b1, 5'h0, 5'b00010, 1'b1, 3'd1, 1'b1, 16'h0011, "pk2");
    step(1'b1, 5'h0, 5'b00010, 1'b1, 3'd1, 1'b1, 16'h0012, "pk3");
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd1, 1'b1, 16'h8013, "pk4");
    step(1'b1, 5'h0, 5'b00100, 1'b1, 3'd2, 1'b0, 16'h8013, "pk5");
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd2, 1'b1, 16'h8021, "pk6");

    // Owner bubble while port 3 waits.
    apply_reset();
    push(0, 16'h0001);
    push(0, 16'h0002);
    push(0, 16'h8003);
    push(3, 16'h8031);
    step(1'b1, 5'h00, 5'b00000, 1'b0, 3'd0, 1'b0, 16'h0000, "bb0");
    step(1'b1, 5'h00, 5'b00001, 1'b1, 3'd0, 1'b0, 16'h0000, "bb1");
    step(1'b1, 5'h01, 5'b00000, 1'b1, 3'd0, 1'b1, 16'h0001, "bb2");
    step(1'b1, 5'h00, 5'b00001, 1'b1, 3'd0, 1'b0, 16'h0001, "bb3");
    step(1'b1, 5'h00, 5'b00001, 1'b1, 3'd0, 1'b1, 16'h0002, "bb4");
    step(1'b1, 5'h00, 5'b00000, 1'b0, 3'd0, 1'b1, 16'h8003, "bb5");
    step(1'b1, 5'h00, 5'b01000, 1'b1, 3'd3, 1'b0, 16'h8003, "bb6");
    step(1'b1, 5'h00, 5'b00000, 1'b0, 3'd3, 1'b1, 16'h8031, "bb7");
`else
    // Flit-level rotation interleaves two 2-flit packets.
    apply_reset();
    push(0, 16'h0001);
    push(0, 16'h8002);
    push(1, 16'h0011);
    push(1, 16'h8012);
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd0, 1'b0, 16'h0000, "il0");
    step(1'b1, 5'h0, 5'b00001, 1'b1, 3'd0, 1'b0, 16'h0000, "il1");
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd0, 1'b1, 16'h0001, "il2");
    step(1'b1, 5'h0, 5'b00010, 1'b1, 3'd1, 1'b0, 16'h0001, "il3");
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd1, 1'b1, 16'h0011, "il4");
    step(1'b1, 5'h0, 5'b00001, 1'b1, 3'd0, 1'b0, 16'h0011, "il5");
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd0, 1'b1, 16'h8002, "il6");
    step(1'b1, 5'h0, 5'b00010, 1'b1, 3'd1, 1'b0, 16'h8002, "il7");
    step(1'b1, 5'h0, 5'b00000, 1'b0, 3'd1, 1'b1, 16'h8012, "il8");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
